emu_clk_freq_meter: RTL and testbench

- Emulation-side clock frequency meter. It is the reader counterpart of the emulation clock divider.
- It counts rising edges of a generated clock (meas_clk) over a programmable window of input_clk cycles.
- It reports the count, which is effectively the achieved numerator/denominator ratio, and flags too-fast, too-slow and lock against an expected count.
- It sits next to the divider outputs in EFFM/emulation builds so the bench and firmware can confirm that each divided clock runs at its intended rate.

---
 rtl/emu_clk_freq_meter.sv | 208 ++++++++++++++++++++
 tb/tb_emu_clk_freq_meter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_clk_freq_meter.sv
// -----------------------------------------------------------------------------
// emu_clk_freq_meter
//
// Clock frequency meter for emulation builds. It counts rising edges of a
// generated clock (meas_clk) over a programmable window of input_clk cycles. It
// reports the count and compares it against an expected count with a +/-
// tolerance, giving too-fast, too-slow and lock indications. It is the reader
// counterpart of the emulation clock divider.
//
// Ports
//   input_clk     sampling clock; all state is on its rising edge. It must run
//                 faster than 2x meas_clk.
//   reset         asynchronous, active-high reset.
//   enable        starts and continues back-to-back measurements.
//   window_len    window length in input_clk cycles, latched at window start.
//   expected_cnt  expected edges per window, latched at window start.
//   tolerance     allowed +/- deviation from expected_cnt, latched at start.
//   meas_clk      clock under test. It is treated as asynchronous data.
//   edge_count    edge count of the last completed window.
//   meas_valid    one-cycle pulse when edge_count updates.
//   too_fast      last count > expected_cnt + tolerance.
//   too_slow      last count < expected_cnt - tolerance.
//   lock          LOCK_WINDOWS consecutive in-range windows have completed.
//   busy          FSM is not in IDLE.
// -----------------------------------------------------------------------------
module emu_clk_freq_meter #(
  parameter int CNT_W        = 32,
  parameter int SYNC_STAGES  = 2,   // must be >= 2
  parameter int LOCK_WINDOWS = 2
) (
  input  logic             input_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] window_len,
  input  logic [CNT_W-1:0] expected_cnt,
  input  logic [15:0]      tolerance,
  input  logic             meas_clk,
  output logic [CNT_W-1:0] edge_count,
  output logic             meas_valid,
  output logic             too_fast,
  output logic             too_slow,
  output logic             lock,
  output logic             busy
);

  // The range intermediates must hold expected_cnt + tolerance without
  // overflow, even when CNT_W is narrower than the 16-bit tolerance.
  localparam int EXT_W = ((CNT_W > 16) ? CNT_W : 16) + 1;
  localparam int LCK_W = (LOCK_WINDOWS < 1) ? 1 : $clog2(LOCK_WINDOWS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LCK_W-1:0] LCK_MAX = LCK_W'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  logic [CNT_W-1:0] win_len_q, exp_q;
  logic [15:0]      tol_q;
  logic [CNT_W-1:0] win_cnt, work_cnt;
  logic [LCK_W-1:0] lock_cnt;

  logic latch_en, abort;

  logic [EXT_W-1:0] exp_x, tol_x, cnt_x, lo_x, hi_sum, hi_x;
  logic             fast_w, slow_w;

  // The synchroniser output is compared with its own delayed copy. A rise is
  // therefore one input_clk cycle wide, whatever the meas_clk duty cycle.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first. No path can then
    // leave a signal unassigned and infer a latch.
    next_state = state;
    latch_en   = 1'b0;
    abort      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && window_len != '0) begin
          next_state = S_ARM;
          latch_en   = 1'b1;
        end
      end
      S_ARM: begin
        if (!enable) begin
          next_state = S_IDLE;
          abort      = 1'b1;
        end else begin
          next_state = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          next_state = S_IDLE;
          abort      = 1'b1;
        end else if (win_cnt == CNT_W'(1)) begin
          next_state = S_REPORT;
        end
      end
      S_REPORT: begin
        // The report always completes. Only the follow-on window depends on
        // enable.
        if (enable && window_len != '0) begin
          next_state = S_ARM;
          latch_en   = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Range check against the latched expectation. The bounds are inclusive.
  // lo is clamped at zero, and hi is clamped at the counter maximum.
  // ---------------------------------------------------------------------------
  always_comb begin
    exp_x  = EXT_W'(exp_q);
    tol_x  = EXT_W'(tol_q);
    cnt_x  = EXT_W'(work_cnt);
    lo_x   = (exp_x >= tol_x) ? (exp_x - tol_x) : '0;
    hi_sum = exp_x + tol_x;
    hi_x   = (hi_sum > EXT_W'(CNT_MAX)) ? EXT_W'(CNT_MAX) : hi_sum;
    fast_w = (cnt_x > hi_x);
    slow_w = (cnt_x < lo_x);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      win_len_q  <= '0;
      exp_q      <= '0;
      tol_q      <= '0;
      win_cnt    <= '0;
      work_cnt   <= '0;
      lock_cnt   <= '0;
      edge_count <= '0;
      meas_valid <= 1'b0;
      too_fast   <= 1'b0;
      too_slow   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], meas_clk};
      prev_q     <= sync_q[SYNC_STAGES-1];
      meas_valid <= 1'b0;

      if (latch_en) begin
        win_len_q <= window_len;
        exp_q     <= expected_cnt;
        tol_q     <= tolerance;
      end

      unique case (state)
        S_ARM: begin
          work_cnt <= '0;
          win_cnt  <= win_len_q;
        end
        S_MEASURE: begin
          if (rise && work_cnt != CNT_MAX) work_cnt <= work_cnt + CNT_W'(1);
          win_cnt <= win_cnt - CNT_W'(1);
        end
        S_REPORT: begin
          edge_count <= work_cnt;
          meas_valid <= 1'b1;
          too_fast   <= fast_w;
          too_slow   <= slow_w;
          if (fast_w || slow_w)        lock_cnt <= '0;
          else if (lock_cnt != LCK_MAX) lock_cnt <= lock_cnt + LCK_W'(1);
        end
        default: ;
      endcase

      // An aborted window breaks the run of consecutive good windows.
      if (abort) lock_cnt <= '0;
    end
  end

  assign lock = (lock_cnt >= LCK_MAX);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_emu_clk_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_emu_clk_freq_meter
//
// Directed bench for emu_clk_freq_meter. The bench uses two instances:
//   dut   : CNT_W=32. Used for window timing, range, lock, abort and reset.
//   dut_b : CNT_W=4. Used for the narrow-counter and bound-clamping cases.
// input_clk has a 10 ns period. Each meas_clk is produced with # delays at
// half-periods that are multiples of 10 ns. Its edges are offset by 2 ns, so
// they never coincide with an input_clk edge. Outputs are sampled 1 ns after
// the rising edge of input_clk.
// -----------------------------------------------------------------------------
module tb_emu_clk_freq_meter;

  localparam int W = 1400;

  logic        input_clk;
  logic        reset;

  logic        enable;
  logic [31:0] window_len, expected_cnt;
  logic [15:0] tolerance;
  logic        meas_clk;
  logic [31:0] edge_count;
  logic        meas_valid, too_fast, too_slow, lock, busy;

  logic        enable_b;
  logic [3:0]  window_len_b, expected_cnt_b;
  logic [15:0] tolerance_b;
  logic        meas_clk_b;
  logic [3:0]  edge_count_b;
  logic        meas_valid_b, too_fast_b, too_slow_b, lock_b, busy_b;

  int meas_half   = 70;    // ns; 70 -> period of 14 input_clk cycles
  bit meas_b_run  = 1'b1;
  int compared    = 0;
  int mismatched  = 0;
  int n;
  int pulses;
  int busy_hits;

  emu_clk_freq_meter #(.CNT_W(32), .SYNC_STAGES(2), .LOCK_WINDOWS(2)) dut (
    .input_clk    (input_clk),
    .reset        (reset),
    .enable       (enable),
    .window_len   (window_len),
    .expected_cnt (expected_cnt),
    .tolerance    (tolerance),
    .meas_clk     (meas_clk),
    .edge_count   (edge_count),
    .meas_valid   (meas_valid),
    .too_fast     (too_fast),
    .too_slow     (too_slow),
    .lock         (lock),
    .busy         (busy)
  );

  emu_clk_freq_meter #(.CNT_W(4), .SYNC_STAGES(2), .LOCK_WINDOWS(2)) dut_b (
    .input_clk    (input_clk),
    .reset        (reset),
    .enable       (enable_b),
    .window_len   (window_len_b),
    .expected_cnt (expected_cnt_b),
    .tolerance    (tolerance_b),
    .meas_clk     (meas_clk_b),
    .edge_count   (edge_count_b),
    .meas_valid   (meas_valid_b),
    .too_fast     (too_fast_b),
    .too_slow     (too_slow_b),
    .lock         (lock_b),
    .busy         (busy_b)
  );

  initial begin
    input_clk = 1'b0;
    forever #5 input_clk = ~input_clk;
  end

  initial begin
    meas_clk = 1'b0;
    #2;
    forever begin
      #(meas_half);
      meas_clk = ~meas_clk;
    end
  end

  // Period of 2 input_clk cycles while running.
  initial begin
    meas_clk_b = 1'b0;
    #2;
    forever begin
      #10;
      if (meas_b_run) meas_clk_b = ~meas_clk_b;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_range(input string tag, input logic [63:0] observed,
                             input logic [63:0] lo, input logic [63:0] hi);
    compared++;
    assert (observed >= lo && observed <= hi) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  // Steps clock edges until meas_valid is seen or the budget runs out. cycles
  // returns the number of edges stepped.
  task automatic wait_valid(input bit on_b, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge input_clk);
      #1;
      cycles++;
    end while (!(on_b ? meas_valid_b : meas_valid) && cycles < budget);
    compared++;
    assert ((on_b ? meas_valid_b : meas_valid) === 1'b1) else begin
      mismatched++;
      $error("FAIL wait_valid: observed no meas_valid in %0d cycles, expected a pulse", budget);
    end
  endtask

  // Restarts dut_b with a new expectation and waits for its first report.
  task automatic run_b(input logic [3:0] exp, input logic [15:0] tol);
    enable_b = 1'b0;
    @(posedge input_clk);
    #1;
    expected_cnt_b = exp;
    tolerance_b    = tol;
    enable_b       = 1'b1;
    wait_valid(1'b1, 40, n);
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    window_len     = W;
    expected_cnt   = 100;
    tolerance      = 1;
    enable_b       = 1'b0;
    window_len_b   = 4'd15;
    expected_cnt_b = 4'd7;
    tolerance_b    = 16'd1;

    // ---- reset state ----
    repeat (3) @(posedge input_clk);
    #1;
    check("rst_edge_count", edge_count, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_too_fast", too_fast, 0);
    check("rst_too_slow", too_slow, 0);
    check("rst_lock", lock, 0);
    check("rst_busy", busy, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    @(posedge input_clk);
    #1;

    // ---- narrow counter: 15-cycle window at 2-cycle period, 7 or 8 edges ----
    enable_b = 1'b1;
    wait_valid(1'b1, 40, n);
    check_range("t5_count_no_wrap", edge_count_b, 7, 8);
    check("t5_in_range_fast", too_fast_b, 0);
    check("t5_in_range_slow", too_slow_b, 0);
    // exp 14, tol 5 gives lo=9. A count of 7..8 is slow. An unclamped 4-bit
    // hi would wrap to 3 and wrongly flag too fast.
    run_b(4'd14, 16'd5);
    check("t5_slow_flag", too_slow_b, 1);
    check("t5_slow_not_fast", too_fast_b, 0);
    // exp 10, tol 6 gives hi = 16, clamped to 15, and lo=4. The count is in range.
    run_b(4'd10, 16'd6);
    check("t5_hi_clamp_fast", too_fast_b, 0);
    check("t5_hi_clamp_slow", too_slow_b, 0);
    // exp 2, tol 5 gives lo clamped to 0. With meas_clk stopped, a count of 0
    // is in range.
    meas_b_run = 1'b0;
    repeat (5) @(posedge input_clk);
    #1;
    run_b(4'd2, 16'd5);
    check("t5_zero_count", edge_count_b, 0);
    check("t5_lo_clamp_slow", too_slow_b, 0);
    check("t5_lo_clamp_fast", too_fast_b, 0);
    enable_b = 1'b0;

    // ---- nominal rate, lock after two windows ----
    enable = 1'b1;
    wait_valid(1'b0, W + 100, n);
    check("t1_latency", n - 1, W + 2);   // one edge samples enable
    check_range("t1_count1", edge_count, 99, 101);
    check("t1_fast1", too_fast, 0);
    check("t1_slow1", too_slow, 0);
    check("t1_lock1", lock, 0);
    wait_valid(1'b0, W + 100, n);
    check("t1_period", n, W + 2);
    check_range("t1_count2", edge_count, 99, 101);
    check("t1_lock2", lock, 1);
    @(posedge input_clk);
    #1;
    check("t1_pulse_width", meas_valid, 0);
    check("t1_busy", busy, 1);

    // ---- slow clock (period 20 gives 70 edges) ----
    repeat (700) @(posedge input_clk);
    meas_half = 100;
    wait_valid(1'b0, 2 * W, n);          // mixed-rate window
    wait_valid(1'b0, W + 100, n);
    check_range("t2_slow_count", edge_count, 69, 71);
    check("t2_slow_flag", too_slow, 1);
    check("t2_slow_not_fast", too_fast, 0);
    check("t2_lock_low", lock, 0);
    wait_valid(1'b0, W + 100, n);
    check("t2_lock_stays_low", lock, 0);
    repeat (700) @(posedge input_clk);
    meas_half = 70;
    wait_valid(1'b0, 2 * W, n);          // mixed-rate window
    wait_valid(1'b0, W + 100, n);
    check_range("t2_back_in_range", edge_count, 99, 101);
    check("t2_lock_after_first", lock, 0);
    wait_valid(1'b0, W + 100, n);
    check("t2_lock_after_second", lock, 1);

    // ---- fast clock drops lock in the same report ----
    repeat (700) @(posedge input_clk);
    #1;
    check("t3_lock_before", lock, 1);
    meas_half = 50;
    wait_valid(1'b0, 2 * W, n);
    check("t3_fast_flag_first", too_fast, 1);
    check("t3_lock_dropped", lock, 0);
    wait_valid(1'b0, W + 100, n);
    check_range("t3_fast_count", edge_count, 139, 141);
    check("t3_fast_flag", too_fast, 1);
    check("t3_fast_not_slow", too_slow, 0);

    // ---- regain lock, then abort mid-window ----
    repeat (700) @(posedge input_clk);
    meas_half = 70;
    wait_valid(1'b0, 2 * W, n);
    wait_valid(1'b0, W + 100, n);
    wait_valid(1'b0, W + 100, n);
    check("t4_lock_pre", lock, 1);
    repeat (501) @(posedge input_clk);
    #1;
    enable = 1'b0;
    @(posedge input_clk);
    #1;
    check("t4_busy_after_abort", busy, 0);
    check("t4_lock_after_abort", lock, 0);
    pulses = 0;
    for (int i = 0; i < W + 10; i++) begin
      @(posedge input_clk);
      #1;
      if (meas_valid) pulses++;
    end
    check("t4_no_meas_valid", pulses, 0);
    check_range("t4_count_held", edge_count, 99, 101);
    check("t4_fast_held", too_fast, 0);
    check("t4_slow_held", too_slow, 0);
    window_len = 0;
    enable     = 1'b1;
    busy_hits  = 0;
    pulses     = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge input_clk);
      #1;
      if (busy) busy_hits++;
      if (meas_valid) pulses++;
    end
    check("t4_zero_window_idle", busy_hits, 0);
    check("t4_zero_window_no_valid", pulses, 0);

    // ---- reset mid-window while locked ----
    window_len = W;
    wait_valid(1'b0, W + 100, n);
    wait_valid(1'b0, W + 100, n);
    check("t6_lock_pre", lock, 1);
    repeat (502) @(posedge input_clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_edge_count", edge_count, 0);
    check("t6_async_meas_valid", meas_valid, 0);
    check("t6_async_too_fast", too_fast, 0);
    check("t6_async_too_slow", too_slow, 0);
    check("t6_async_lock", lock, 0);
    check("t6_async_busy", busy, 0);
    repeat (2) @(posedge input_clk);
    #1;
    reset = 1'b0;
    wait_valid(1'b0, W + 100, n);
    check("t6_latency_after_reset", n - 1, W + 2);

    // ---- enable falls during REPORT: the report completes, then IDLE ----
    repeat (W + 1) @(posedge input_clk);
    #1;
    enable = 1'b0;
    @(posedge input_clk);
    #1;
    check("t6_report_completes", meas_valid, 1);
    check("t6_idle_after_report", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
